// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser plus per-bit debounce filter with edge pulses
module sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= sw_raw;
      sync2   <= sync1;
      sw_rise <= '0;
      sw_fall <= '0;
      // Any cycle where the synchronised level agrees with sw_db restarts the count.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_db[i] <= sync2[i];
          cnt[i]   <= '0;
          if (sync2[i]) begin
            sw_rise[i] <= 1'b1;
          end else begin
            sw_fall[i] <= 1'b1;
          end
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - scoreboard bench for sw_debounce against a sliding-window reference model
module tb_sw_debounce;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int pass_cnt;
  int total_cnt;

  logic [3*W:0] exp_q[$];

  sw_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_db(sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_changed(sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a level is accepted once the last D synchronised samples all disagree with it.
  initial begin
    logic [W-1:0] raw_q[$];
    logic [W-1:0] win[$];
    logic [W-1:0] m_db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] s2;
    logic         all_diff;
    raw_q = '{8'h00, 8'h00};
    m_db  = '0;
    forever begin
      @(posedge clk);
      rise = '0;
      fall = '0;
      if (rst) begin
        raw_q = '{8'h00, 8'h00};
        win.delete();
        m_db = '0;
      end else begin
        s2 = raw_q.pop_front();
        raw_q.push_back(sw_raw);
        win.push_back(s2);
        if (win.size() > D) void'(win.pop_front());
        if (win.size() == D) begin
          for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            foreach (win[k]) if (win[k][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) begin
              if (m_db[i]) fall[i] = 1'b1;
              else rise[i] = 1'b1;
              m_db[i] = ~m_db[i];
            end
          end
        end
      end
      exp_q.push_back({m_db, rise, fall, |(rise | fall)});
    end
  end

  always @(negedge clk) begin
    logic [3*W:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if ({sw_db, sw_rise, sw_fall, sw_changed} == e) pass_cnt++;
      else $display("FAIL scoreboard t=%0t got db=%h rise=%h fall=%h chg=%b want db=%h rise=%h fall=%h chg=%b",
                    $time, sw_db, sw_rise, sw_fall, sw_changed,
                    e[3*W:2*W+1], e[2*W:W+1], e[W:1], e[0]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  // Counts edges until sw_changed is seen; a timeout is recorded as a failed check.
  task automatic wait_change(input string name, input int want_edges);
    int n;
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sw_changed) break;
    end
    total_cnt++;
    if (sw_changed && n == want_edges) pass_cnt++;
    else $display("FAIL %s latency got=%0d edges (changed=%b) want=%0d", name, n, sw_changed, want_edges);
  endtask

  initial begin
    int hold;
    pass_cnt  = 0;
    total_cnt = 0;
    rst    = 1'b1;
    sw_raw = 8'hFF;

    // Reset values, then power-up acceptance of all-ones
    step(3);
    check("reset_db", sw_db, 8'h00);
    rst = 1'b0;
    wait_change("powerup", 6);
    check("powerup_rise", sw_rise, 8'hFF);
    check("powerup_db", sw_db, 8'hFF);
    step(1);

    // Clean step
    sw_raw = 8'h00;
    wait_change("to_zero", 6);
    check("to_zero_fall", sw_fall, 8'hFF);
    step(1);
    sw_raw = 8'h01;
    wait_change("clean_step", 6);
    check("clean_rise", sw_rise, 8'h01);
    check("clean_fall", sw_fall, 8'h00);
    step(3);

    // Bounce rejection on bit 3
    for (int k = 0; k < 4; k++) begin
      sw_raw[3] = (k % 2 == 0);
      step(3);
    end
    step(10);
    check("bounce_db", sw_db, 8'h01);

    // Bounce then settle on bit 7
    sw_raw[7] = 1'b1;
    step(2);
    sw_raw[7] = 1'b0;
    step(1);
    sw_raw[7] = 1'b1;
    wait_change("settle", 6);
    check("settle_rise", sw_rise, 8'h80);
    step(3);

    // Simultaneous opposite edges
    sw_raw = 8'hF0;
    step(10);
    check("pre_opp_db", sw_db, 8'hF0);
    sw_raw = 8'h0F;
    wait_change("opposite", 6);
    check("opp_db", sw_db, 8'h0F);
    check("opp_rise", sw_rise, 8'h0F);
    check("opp_fall", sw_fall, 8'hF0);
    step(3);

    // Reset mid-count on bit 2
    sw_raw = 8'h00;
    step(10);
    sw_raw = 8'h04;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wait_change("mid_reset", 6);
    check("mid_reset_rise", sw_rise, 8'h04);
    step(3);

    // Randomised bounce, holds and occasional resets
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 2));
        rst = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) begin
        sw_raw = 8'($urandom);
        hold = $urandom_range(5, 12);
      end else begin
        sw_raw = sw_raw ^ 8'($urandom);
        hold = $urandom_range(1, 3);
      end
      step(hold);
    end
    step(12);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
